rsa_batch_sequencer: RTL and testbench
======================================

// Module: rsa_batch_sequencer
// PURPOSE
//   Batch controller that feeds a single rsa_unit (WIDTH-bit, Montgomery) from a plaintext FIFO.
//   Per byte it loads P, pulses clear, holds ena until eoc, then stores C into a ciphertext FIFO.
//   Sits between the peripheral register file and rsa_unit, in place of the single-shot start/stop logic.
//   E, M and Const are wired to rsa_unit directly from the register file; this block does not touch them.
// PARAMETERS
//   WIDTH    8    operand/result width; must match rsa_unit WIDTH
//   DEPTH    4    entries in each FIFO; power of 2, >=2
//   TIMEOUT  255  max RUN cycles per operand before watchdog abort; 1..255 (8-bit counter)
// PORTS
//   clk         in   1      clock
//   rst_n       in   1      synchronous reset, active-low
//   go          in   1      1-cycle pulse: start processing queued plaintext
//   abort       in   1      1-cycle pulse: cancel batch, flush plaintext FIFO
//   pt_push     in   1      push pt_data into plaintext FIFO
//   pt_data     in   WIDTH  plaintext byte
//   pt_full     out  1      plaintext FIFO full
//   ct_pop      in   1      pop ciphertext FIFO head
//   ct_data     out  WIDTH  ciphertext FIFO head; 0 when empty
//   ct_empty    out  1      ciphertext FIFO empty
//   ct_count    out  clog2(DEPTH)+1  ciphertext entries held
//   rsa_p       out  WIDTH  operand to rsa_unit.P; registered, stable through CLEAR/RUN
//   rsa_ena     out  1      rsa_unit.ena
//   rsa_clear   out  1      rsa_unit.clear
//   rsa_eoc     in   1      rsa_unit.eoc
//   rsa_c       in   WIDTH  rsa_unit.C
//   busy        out  1      FSM not in IDLE/DONE
//   done_irq    out  1      sticky: batch finished; cleared by go or abort
//   err         out  2      sticky {timeout, pt_overflow}; cleared by go or abort
// BEHAVIOUR
//   Reset: FSM=IDLE, both FIFOs empty, rsa_p=0, rsa_ena=0, rsa_clear=0, done_irq=0, err=0, ct_data=0.
//   FSM:
//   - IDLE: go -> LOAD if PT FIFO non-empty, else -> DONE (done_irq=1 next cycle).
//   - LOAD (1 cyc): pop PT head into rsa_p -> CLEAR.
//   - CLEAR (1 cyc): rsa_clear=1, rsa_ena=0; watchdog=0 -> RUN.
//   - RUN: rsa_ena=1; watchdog+1 per cycle.
//     eoc sampled 1 -> STORE, ena drops the next cycle.
//     watchdog==TIMEOUT w/o eoc -> err[1]=1, rsa_clear pulse, flush PT FIFO -> DONE.
//   - STORE: ena=0; if CT not full, write rsa_c, then LOAD (PT non-empty) or DONE (PT empty).
//     If CT full, stall in STORE until a pop frees space; the pop and the write may share a cycle.
//   - DONE: done_irq=1; go -> as IDLE; otherwise hold.
//   Latency: go-to-rsa_ena = 3 cycles (LOAD, CLEAR, RUN).
//   Per-operand overhead beyond rsa_unit compute = 3 cycles (LOAD, CLEAR, STORE).
//   go is ignored while busy. abort in any state wins over go and eoc:
//     next cycle FSM=IDLE, rsa_ena=0, rsa_clear=1 for 1 cycle, PT flushed.
//     CT contents kept; done_irq/err cleared.
//   PT FIFO: push allowed in any state; pushes during RUN join the current batch.
//     Push when full: dropped, err[0]=1.
//     Push+pop same cycle when full: pop first, push accepted.
//   CT FIFO: pop when empty ignored. Pointers wrap mod DEPTH; count saturates at DEPTH.
//   rsa_eoc outside RUN is ignored. Reset mid-RUN returns all state to reset values in one cycle.
// TESTING
//   - Stub rsa_unit: eoc 10 cycles after ena; C=P^E mod M with E=3, M=33.
//     Push 5, go -> ena at go+3, CT holds 26, done_irq=1, busy=0.
//   - Push 2,3,4,5, go -> CT pops 8,27,31,26 in order, ct_count reaches 4, exactly 4 clear pulses.
//   - DEPTH=4, push 5 bytes while idle -> 5th dropped, err=2'b01, pt_full=1; go clears err.
//   - Stub never asserts eoc, TIMEOUT=20 -> err=2'b10 at go+23, PT empty, done_irq=1.
//   - CT full with 1 operand pending -> FSM holds STORE, ena=0; one ct_pop -> write next cycle, DONE.
//   - abort mid-RUN -> rsa_ena=0 and rsa_clear=1 next cycle, IDLE, PT empty, CT unchanged; go with empty PT -> DONE.

Source files
------------

// File: rtl/rsa_batch_sequencer.sv
// Batch sequencer for a single rsa_unit: drains a plaintext FIFO through the unit one
// operand at a time and collects results in a ciphertext FIFO, with watchdog and abort.
module rsa_batch_sequencer #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   go,
  input  logic                   abort,
  input  logic                   pt_push,
  input  logic [WIDTH-1:0]       pt_data,
  output logic                   pt_full,
  input  logic                   ct_pop,
  output logic [WIDTH-1:0]       ct_data,
  output logic                   ct_empty,
  output logic [$clog2(DEPTH):0] ct_count,
  output logic [WIDTH-1:0]       rsa_p,
  output logic                   rsa_ena,
  output logic                   rsa_clear,
  input  logic                   rsa_eoc,
  input  logic [WIDTH-1:0]       rsa_c,
  output logic                   busy,
  output logic                   done_irq,
  output logic [1:0]             err,
  output logic [2:0]             state_dbg
);
  // Handshake: pt_push and ct_pop are single-cycle strobes with no ready; a push into a
  // full FIFO (without a same-cycle pop) is dropped and flagged, a pop of an empty FIFO is ignored.
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CLEAR = 3'd2,
    S_RUN   = 3'd3,
    S_STORE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] pt_mem [DEPTH];
  logic [AW-1:0]    pt_rd, pt_wr;
  logic [CW-1:0]    pt_cnt;
  logic [WIDTH-1:0] ct_mem [DEPTH];
  logic [AW-1:0]    ct_rd, ct_wr;
  logic [CW-1:0]    ct_cnt;

  logic [7:0] wd, wd_inc;
  logic       clr_pulse;
  logic       timeout_hit;
  logic       pt_empty, pt_pop, pt_flush, pt_wr_en, pt_ovf;
  logic       ct_full, ct_pop_en, ct_wr_en;
  logic       go_acc;

  assign pt_empty  = (pt_cnt == '0);
  assign pt_full   = (pt_cnt == CW'(DEPTH));
  assign pt_pop    = (state == S_LOAD);
  assign pt_flush  = abort | timeout_hit;
  assign pt_wr_en  = pt_push && (!pt_full || pt_pop) && !pt_flush;
  assign pt_ovf    = pt_push && pt_full && !pt_pop;

  assign ct_empty  = (ct_cnt == '0);
  assign ct_full   = (ct_cnt == CW'(DEPTH));
  assign ct_pop_en = ct_pop && !ct_empty;
  // A pop in the same cycle frees the slot the stalled result is written into.
  assign ct_wr_en  = (state == S_STORE) && !abort && (!ct_full || ct_pop_en);
  assign ct_data   = ct_empty ? '0 : ct_mem[ct_rd];
  assign ct_count  = ct_cnt;

  assign wd_inc    = wd + 8'd1;
  assign go_acc    = go && !abort && ((state == S_IDLE) || (state == S_DONE));

  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (go) state_next = pt_empty ? S_DONE : S_LOAD;
      S_LOAD:         state_next = S_CLEAR;
      S_CLEAR:        state_next = S_RUN;
      S_RUN: begin
        if (rsa_eoc) begin
          state_next = S_STORE;
        end else if (wd_inc == 8'(TIMEOUT)) begin
          timeout_hit = 1'b1;
          state_next  = S_DONE;
        end
      end
      S_STORE:        if (ct_wr_en) state_next = pt_empty ? S_DONE : S_LOAD;
      default:        state_next = S_IDLE;
    endcase
    if (abort) begin
      state_next  = S_IDLE;
      timeout_hit = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wd        <= '0;
      clr_pulse <= 1'b0;
      err       <= 2'b00;
      rsa_p     <= '0;
    end else begin
      state     <= state_next;
      clr_pulse <= abort | timeout_hit;
      if (state == S_CLEAR)    wd <= '0;
      else if (state == S_RUN) wd <= wd_inc;
      if (state == S_LOAD)     rsa_p <= pt_mem[pt_rd];
      if (abort) begin
        err <= 2'b00;
      end else begin
        err[1] <= (go_acc ? 1'b0 : err[1]) | timeout_hit;
        err[0] <= (go_acc ? 1'b0 : err[0]) | pt_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pt_rd  <= '0;
      pt_wr  <= '0;
      pt_cnt <= '0;
    end else if (pt_flush) begin
      pt_rd  <= pt_wr;
      pt_cnt <= '0;
    end else begin
      if (pt_wr_en) pt_wr <= pt_wr + AW'(1);
      if (pt_pop)   pt_rd <= pt_rd + AW'(1);
      pt_cnt <= pt_cnt + CW'(pt_wr_en) - CW'(pt_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (pt_wr_en) pt_mem[pt_wr] <= pt_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ct_rd  <= '0;
      ct_wr  <= '0;
      ct_cnt <= '0;
    end else begin
      if (ct_wr_en)  ct_wr <= ct_wr + AW'(1);
      if (ct_pop_en) ct_rd <= ct_rd + AW'(1);
      ct_cnt <= ct_cnt + CW'(ct_wr_en) - CW'(ct_pop_en);
    end
  end

  always_ff @(posedge clk) begin
    if (ct_wr_en) ct_mem[ct_wr] <= rsa_c;
  end

  assign rsa_ena   = (state == S_RUN);
  assign rsa_clear = (state == S_CLEAR) || clr_pulse;
  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign done_irq  = (state == S_DONE);
  assign state_dbg = state;
endmodule

// File: tb/tb_rsa_batch_sequencer.sv
// Bench for rsa_batch_sequencer with a stub rsa_unit (C = P^3 mod 33, eoc on the 10th ena cycle).
module tb_rsa_batch_sequencer;
  localparam int W = 8;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_STORE = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  logic         clk, rst_n, go, abort, pt_push, pt_full, ct_pop, ct_empty;
  logic [W-1:0] pt_data, ct_data, rsa_p, rsa_c;
  logic [2:0]   ct_count, state_dbg;
  logic         rsa_ena, rsa_clear, rsa_eoc, busy, done_irq;
  logic [1:0]   err;

  int checks = 0;
  int errors = 0;
  int clear_cnt = 0;
  logic [W-1:0] exp_q[$];

  rsa_batch_sequencer #(.WIDTH(W), .DEPTH(4), .TIMEOUT(20)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .abort(abort),
    .pt_push(pt_push), .pt_data(pt_data), .pt_full(pt_full),
    .ct_pop(ct_pop), .ct_data(ct_data), .ct_empty(ct_empty), .ct_count(ct_count),
    .rsa_p(rsa_p), .rsa_ena(rsa_ena), .rsa_clear(rsa_clear),
    .rsa_eoc(rsa_eoc), .rsa_c(rsa_c),
    .busy(busy), .done_irq(done_irq), .err(err), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "global timeout");
  end

  // stub rsa_unit
  function automatic logic [W-1:0] cube33(input logic [W-1:0] p);
    int v;
    v = int'(p);
    return W'((v * v * v) % 33);
  endfunction

  logic [3:0] stub_cnt;
  bit         stub_hang = 1'b0;
  always @(posedge clk) begin
    if (!rst_n || rsa_clear) stub_cnt <= 4'd0;
    else if (rsa_ena && stub_cnt != 4'd15) stub_cnt <= stub_cnt + 4'd1;
  end
  assign rsa_eoc = rsa_ena && !stub_hang && (stub_cnt == 4'd9);
  assign rsa_c   = cube33(rsa_p);

  always @(negedge clk) if (rst_n && rsa_clear) clear_cnt <= clear_cnt + 1;

  // scoreboard: every effective ct pop is compared with the queue head
  always @(negedge clk) begin
    if (rst_n && ct_pop && !ct_empty) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ct_pop_unexpected: got %0d, expected no entry", ct_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (ct_data !== e) begin
          errors++;
          $display("FAIL ct_data: got %0d, expected %0d", ct_data, e);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pt(input logic [W-1:0] v);
    pt_push = 1'b1;
    pt_data = v;
    tick();
    pt_push = 1'b0;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic pop_ct();
    ct_pop = 1'b1;
    tick();
    ct_pop = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done_irq && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (done_irq !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: done_irq=%b after %0d cycles, expected 1", name, done_irq, n);
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checks++;
    if (state_dbg !== ST_IDLE || busy !== 1'b0 || done_irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_fsm: state=%0d busy=%b done=%b, expected 0 0 0", state_dbg, busy, done_irq);
    end
    checks++;
    if (ct_empty !== 1'b1 || ct_count !== 3'd0 || ct_data !== 8'd0 || pt_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_fifo: ct_empty=%b cnt=%0d data=%0d pt_full=%b, expected 1 0 0 0",
               ct_empty, ct_count, ct_data, pt_full);
    end
    checks++;
    if (rsa_p !== 8'd0 || rsa_ena !== 1'b0 || rsa_clear !== 1'b0 || err !== 2'b00) begin
      errors++;
      $display("FAIL reset_rsa: p=%0d ena=%b clear=%b err=%b, expected 0 0 0 00",
               rsa_p, rsa_ena, rsa_clear, err);
    end
  endtask

  task automatic test_single();
    push_pt(8'd5);
    exp_q.push_back(8'd26);
    pulse_go();
    tick();
    checks++;
    if (rsa_ena !== 1'b0 || rsa_clear !== 1'b1) begin
      errors++;
      $display("FAIL single_clear: ena=%b clear=%b at go+2, expected 0 1", rsa_ena, rsa_clear);
    end
    tick();
    checks++;
    if (rsa_ena !== 1'b1 || rsa_p !== 8'd5) begin
      errors++;
      $display("FAIL single_ena: ena=%b p=%0d at go+3, expected 1 5", rsa_ena, rsa_p);
    end
    wait_done("single", 60);
    checks++;
    if (busy !== 1'b0 || ct_count !== 3'd1 || err !== 2'b00) begin
      errors++;
      $display("FAIL single_end: busy=%b ct_count=%0d err=%b, expected 0 1 00", busy, ct_count, err);
    end
    pop_ct();
  endtask

  task automatic test_batch();
    int clr0;
    push_pt(8'd2);
    push_pt(8'd3);
    push_pt(8'd4);
    push_pt(8'd5);
    exp_q.push_back(8'd8);
    exp_q.push_back(8'd27);
    exp_q.push_back(8'd31);
    exp_q.push_back(8'd26);
    clr0 = clear_cnt;
    pulse_go();
    wait_done("batch", 200);
    checks++;
    if (ct_count !== 3'd4) begin
      errors++;
      $display("FAIL batch_count: ct_count=%0d, expected 4", ct_count);
    end
    checks++;
    if (clear_cnt - clr0 !== 4) begin
      errors++;
      $display("FAIL batch_clears: clear pulses=%0d, expected 4", clear_cnt - clr0);
    end
    for (int i = 0; i < 4; i++) pop_ct();
  endtask

  task automatic test_overflow_and_ct_full();
    logic [W-1:0] v;
    for (int i = 0; i < 4; i++) begin
      v = W'($urandom_range(0, 255));
      push_pt(v);
      exp_q.push_back(cube33(v));
    end
    checks++;
    if (pt_full !== 1'b1 || err !== 2'b00) begin
      errors++;
      $display("FAIL ovf_full: pt_full=%b err=%b, expected 1 00", pt_full, err);
    end
    push_pt(W'($urandom_range(0, 255)));
    checks++;
    if (pt_full !== 1'b1 || err !== 2'b01) begin
      errors++;
      $display("FAIL ovf_drop: pt_full=%b err=%b, expected 1 01", pt_full, err);
    end
    pulse_go();
    checks++;
    if (err !== 2'b00 || state_dbg !== ST_LOAD) begin
      errors++;
      $display("FAIL ovf_go_clear: err=%b state=%0d, expected 00 1", err, state_dbg);
    end
    v = W'($urandom_range(0, 255));
    push_pt(v);
    exp_q.push_back(cube33(v));
    checks++;
    if (err !== 2'b00 || pt_full !== 1'b1) begin
      errors++;
      $display("FAIL ovf_push_pop: err=%b pt_full=%b, expected 00 1", err, pt_full);
    end
    begin
      int n = 0;
      while (!(state_dbg == ST_STORE && ct_count == 3'd4) && n < 300) begin
        tick();
        n++;
      end
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (state_dbg !== ST_STORE || rsa_ena !== 1'b0 || ct_count !== 3'd4 || done_irq !== 1'b0) begin
      errors++;
      $display("FAIL ctfull_stall: state=%0d ena=%b ct_count=%0d done=%b, expected 4 0 4 0",
               state_dbg, rsa_ena, ct_count, done_irq);
    end
    pop_ct();
    checks++;
    if (state_dbg !== ST_DONE || ct_count !== 3'd4) begin
      errors++;
      $display("FAIL ctfull_release: state=%0d ct_count=%0d, expected 5 4", state_dbg, ct_count);
    end
    for (int i = 0; i < 4; i++) pop_ct();
  endtask

  task automatic test_timeout();
    stub_hang = 1'b1;
    push_pt(W'($urandom_range(0, 255)));
    pulse_go();
    for (int i = 0; i < 21; i++) begin
      pt_push = (i == 4 || i == 5);
      pt_data = W'($urandom_range(0, 255));
      tick();
    end
    pt_push = 1'b0;
    checks++;
    if (err !== 2'b00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: err=%b busy=%b at go+22, expected 00 1", err, busy);
    end
    tick();
    checks++;
    if (err !== 2'b10 || done_irq !== 1'b1 || rsa_clear !== 1'b1 || rsa_ena !== 1'b0) begin
      errors++;
      $display("FAIL timeout_hit: err=%b done=%b clear=%b ena=%b at go+23, expected 10 1 1 0",
               err, done_irq, rsa_clear, rsa_ena);
    end
    stub_hang = 1'b0;
    pulse_go();
    checks++;
    if (state_dbg !== ST_DONE || err !== 2'b00 || ct_count !== 3'd0) begin
      errors++;
      $display("FAIL timeout_flush: state=%0d err=%b ct_count=%0d, expected 5 00 0",
               state_dbg, err, ct_count);
    end
  endtask

  task automatic test_abort();
    logic [W-1:0] v;
    v = W'($urandom_range(0, 255));
    push_pt(v);
    exp_q.push_back(cube33(v));
    pulse_go();
    wait_done("abort_pre", 60);
    push_pt(W'($urandom_range(0, 255)));
    push_pt(W'($urandom_range(0, 255)));
    pulse_go();
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (rsa_ena !== 1'b1) begin
      errors++;
      $display("FAIL abort_setup: ena=%b, expected 1", rsa_ena);
    end
    abort = 1'b1;
    go = 1'b1;
    tick();
    abort = 1'b0;
    go = 1'b0;
    checks++;
    if (rsa_ena !== 1'b0 || rsa_clear !== 1'b1 || state_dbg !== ST_IDLE || ct_count !== 3'd1) begin
      errors++;
      $display("FAIL abort_next: ena=%b clear=%b state=%0d ct_count=%0d, expected 0 1 0 1",
               rsa_ena, rsa_clear, state_dbg, ct_count);
    end
    tick();
    checks++;
    if (rsa_clear !== 1'b0 || done_irq !== 1'b0 || err !== 2'b00) begin
      errors++;
      $display("FAIL abort_after: clear=%b done=%b err=%b, expected 0 0 00", rsa_clear, done_irq, err);
    end
    pulse_go();
    checks++;
    if (state_dbg !== ST_DONE || done_irq !== 1'b1 || ct_count !== 3'd1) begin
      errors++;
      $display("FAIL abort_go_empty: state=%0d done=%b ct_count=%0d, expected 5 1 1",
               state_dbg, done_irq, ct_count);
    end
    pop_ct();
    pop_ct();
    checks++;
    if (ct_count !== 3'd0 || ct_data !== 8'd0 || ct_empty !== 1'b1) begin
      errors++;
      $display("FAIL ct_empty_pop: ct_count=%0d data=%0d empty=%b, expected 0 0 1",
               ct_count, ct_data, ct_empty);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] v;
    int n;
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        v = W'($urandom_range(0, 255));
        push_pt(v);
        exp_q.push_back(cube33(v));
      end
      pulse_go();
      wait_done("b2b", 200);
      checks++;
      if (ct_count !== 3'(n)) begin
        errors++;
        $display("FAIL b2b_count: ct_count=%0d, expected %0d", ct_count, n);
      end
      for (int i = 0; i < n; i++) pop_ct();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    go = 1'b0;
    abort = 1'b0;
    pt_push = 1'b0;
    pt_data = '0;
    ct_pop = 1'b0;
    test_reset();
    test_single();
    test_batch();
    test_overflow_and_ct_full();
    test_timeout();
    test_abort();
    test_back_to_back();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
